// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;

    // Debounce FSM states
    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRelease
    } state_e;

    // Frame result encoding: {valid, code}; valid=0 means no single key
    localparam logic [4:0] NO_KEY = 5'b0_0000;

    // Key code from row and column index
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs (keypad columns, buttons).
module sync2 #(
    parameter int unsigned       Width    = 4,
    parameter logic [Width-1:0]  ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    // Two-stage capture to settle metastability
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, accumulates one frame of
// column samples, and debounces single-key frames into one key_valid pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [3:0] row_o,
    input  logic [3:0] col_i,
    output logic [3:0] key_code_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int unsigned    DivW      = $clog2(SCAN_DIV);
    localparam int unsigned    CntW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntTarget = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam bit             OneScan   = (DEBOUNCE_SCANS == 1);

    logic [3:0]      col_sync;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      row_q, row_d;
    // Low bits seen so far this frame: 0, 1, or 2 meaning "two or more"
    logic [1:0]      acc_n_q, acc_n_d;
    logic [3:0]      acc_code_q, acc_code_d;
    logic [1:0]      row_n;
    logic [1:0]      row_col;
    logic [1:0]      merged_n;
    logic [3:0]      merged_code;
    logic [4:0]      frame_res;
    logic            row_sample;
    logic            frame_end;

    state_e          state_q, state_d;
    logic [3:0]      cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;

    sync2 #(
        .Width    (4),
        .ResetVal (4'hF)
    ) u_col_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (col_i),
        .q_o   (col_sync)
    );

    assign row_sample = (div_q == DivLast);
    assign frame_end  = row_sample && (row_q == 2'd3);

    // Scan divider and row rotation
    always_comb begin
        div_d = div_q + DivW'(1);
        row_d = row_q;
        if (row_sample) begin
            div_d = '0;
            row_d = row_q + 2'd1;
        end
    end

    // Merge the current row's column sample into the frame accumulator
    always_comb begin
        row_n   = 2'd0;
        row_col = 2'd0;
        for (int i = 0; i < COLS; i++) begin
            if (!col_sync[i]) begin
                if (row_n == 2'd0) row_col = 2'(i);
                if (row_n != 2'd2) row_n = row_n + 2'd1;
            end
        end

        merged_n    = acc_n_q;
        merged_code = acc_code_q;
        if (row_n != 2'd0) begin
            if (acc_n_q == 2'd0 && row_n == 2'd1) begin
                merged_n    = 2'd1;
                merged_code = key_code(row_q, row_col);
            end else begin
                merged_n = 2'd2;
            end
        end
        frame_res = (merged_n == 2'd1) ? {1'b1, merged_code} : NO_KEY;

        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        if (frame_end) begin
            acc_n_d    = 2'd0;
            acc_code_d = 4'd0;
        end else if (row_sample) begin
            acc_n_d    = merged_n;
            acc_code_d = merged_code;
        end
    end

    // Debounce FSM, stepped once per frame
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        cnt_inc     = (cnt_q == CntTarget) ? cnt_q : cnt_q + CntOne;

        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_res[4]) begin
                        cand_d = frame_res[3:0];
                        if (OneScan) begin
                            state_d     = StPressed;
                            key_code_d  = frame_res[3:0];
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end else begin
                            state_d = StDebPress;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StDebPress: begin
                    if (frame_res == {1'b1, cand_q}) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntTarget) begin
                            state_d     = StPressed;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end else if (frame_res[4]) begin
                        cand_d = frame_res[3:0];
                        cnt_d  = CntOne;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (frame_res != {1'b1, cand_q}) begin
                        if (OneScan) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StDebRelease;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StDebRelease: begin
                    if (frame_res == {1'b1, cand_q}) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntTarget) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q       <= '0;
            row_q       <= 2'd0;
            acc_n_q     <= 2'd0;
            acc_code_q  <= 4'd0;
            state_q     <= StIdle;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            row_q       <= row_d;
            acc_n_q     <= acc_n_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row_o       = ~(ROWS'(1) << row_q);
    assign key_code_o  = key_code_q;
    assign key_valid_o = key_valid_q;
    assign key_held_o  = (state_q == StPressed) || (state_q == StDebRelease);

endmodule
